// File: rtl/coax_tx_control_if.sv
// SPI-side and coax-TX-side signal bundle for coax_tx_control.
// The master modport is the sequencer; slave is spi_device/transmitter side.
interface coax_tx_control_if;
    logic       spi_cs;
    logic [7:0] spi_rx_data;
    logic       spi_rx_strobe;
    logic [7:0] spi_tx_data;
    logic       spi_tx_strobe;
    logic [9:0] tx_data;
    logic       tx_load_strobe;
    logic       tx_full;
    logic       tx_start;
    logic       tx_reset;
    logic       tx_active;
    logic       rx_enable;
    logic       loopback;

    modport master (
        input  spi_cs,
        input  spi_rx_data,
        input  spi_rx_strobe,
        output spi_tx_data,
        output spi_tx_strobe,
        output tx_data,
        output tx_load_strobe,
        input  tx_full,
        output tx_start,
        output tx_reset,
        input  tx_active,
        output rx_enable,
        output loopback
    );

    modport slave (
        output spi_cs,
        output spi_rx_data,
        output spi_rx_strobe,
        input  spi_tx_data,
        input  spi_tx_strobe,
        input  tx_data,
        input  tx_load_strobe,
        output tx_full,
        input  tx_start,
        input  tx_reset,
        output tx_active,
        input  rx_enable,
        input  loopback
    );
endinterface

// File: rtl/coax_tx_control.sv
// SPI command sequencer: packs byte pairs into 10-bit coax words,
// kicks the buffered transmitter, and holds the RX mux configuration.
module coax_tx_control #(
    parameter int         MAX_WORDS      = 1024,
    parameter logic [1:0] DEFAULT_CONFIG = 2'b01
) (
    input  logic               clk,
    input  logic               reset,
    coax_tx_control_if.master  bus
);
    localparam int CW = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {
        IDLE, CMD, STATUS, TX_HI, TX_LO, CFG, DISCARD, START
    } state_t;

    state_t        state, state_n;
    logic          cs_s1, cs_s2, cs_d;
    logic          cs_fall, cs_rise, rx_ok;
    logic [1:0]    hi, hi_n;
    logic [1:0]    cfg, cfg_n;
    logic [CW-1:0] count, count_n;
    logic          overflow, overflow_n;
    logic [7:0]    stx_data, stx_data_n;
    logic          stx_stb, stx_stb_n;
    logic [9:0]    txd, txd_n;
    logic          load, load_n;
    logic          start, start_n;
    logic          txrst, txrst_n;
    logic [7:0]    status;

    // Sync chain resets to "selected" so a CS held low through reset
    // does not fabricate a falling edge; the parser waits for a real one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_s1 <= 1'b0;
            cs_s2 <= 1'b0;
            cs_d  <= 1'b0;
        end else begin
            cs_s1 <= bus.spi_cs;
            cs_s2 <= cs_s1;
            cs_d  <= cs_s2;
        end
    end

    assign cs_fall = cs_d & ~cs_s2;
    assign cs_rise = ~cs_d & cs_s2;
    assign rx_ok   = bus.spi_rx_strobe & ~cs_s2;

    assign status = {3'b000, overflow, bus.tx_full,
                     bus.tx_active, cfg[1], cfg[0]};

    always_comb begin
        state_n    = state;
        hi_n       = hi;
        cfg_n      = cfg;
        count_n    = count;
        overflow_n = overflow;
        stx_data_n = stx_data;
        stx_stb_n  = 1'b0;
        txd_n      = txd;
        load_n     = 1'b0;
        start_n    = (state == START);
        txrst_n    = 1'b0;
        if (cs_fall) begin
            state_n = CMD;
        end else begin
            unique case (state)
                IDLE: state_n = IDLE;
                CMD: begin
                    if (cs_rise) begin
                        state_n = IDLE;
                    end else if (rx_ok) begin
                        case (bus.spi_rx_data)
                            8'h01: begin
                                state_n    = STATUS;
                                stx_stb_n  = 1'b1;
                                stx_data_n = status;
                            end
                            8'h02: begin
                                state_n = TX_HI;
                                count_n = '0;
                            end
                            8'h03: state_n = CFG;
                            8'h04: begin
                                state_n    = DISCARD;
                                txrst_n    = 1'b1;
                                overflow_n = 1'b0;
                            end
                            default: state_n = DISCARD;
                        endcase
                    end
                end
                STATUS: begin
                    if (cs_rise) begin
                        state_n = IDLE;
                    end else if (rx_ok) begin
                        stx_stb_n  = 1'b1;
                        stx_data_n = status;
                    end
                end
                CFG: begin
                    if (cs_rise) begin
                        state_n = IDLE;
                    end else if (rx_ok) begin
                        cfg_n   = bus.spi_rx_data[1:0];
                        state_n = DISCARD;
                    end
                end
                TX_HI, TX_LO: begin
                    if (cs_rise) begin
                        state_n = (count != '0) ? START : IDLE;
                    end else if (rx_ok && state == TX_HI) begin
                        hi_n    = bus.spi_rx_data[1:0];
                        state_n = TX_LO;
                    end else if (rx_ok) begin
                        state_n = TX_HI;
                        if (!bus.tx_full && count < CW'(MAX_WORDS)) begin
                            txd_n   = {hi, bus.spi_rx_data};
                            load_n  = 1'b1;
                            count_n = count + CW'(1);
                        end else begin
                            overflow_n = 1'b1;
                        end
                    end
                end
                DISCARD: begin
                    if (cs_rise)
                        state_n = IDLE;
                end
                START: state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            hi       <= 2'b00;
            cfg      <= DEFAULT_CONFIG;
            count    <= '0;
            overflow <= 1'b0;
            stx_data <= 8'h00;
            stx_stb  <= 1'b0;
            txd      <= 10'h000;
            load     <= 1'b0;
            start    <= 1'b0;
            txrst    <= 1'b0;
        end else begin
            state    <= state_n;
            hi       <= hi_n;
            cfg      <= cfg_n;
            count    <= count_n;
            overflow <= overflow_n;
            stx_data <= stx_data_n;
            stx_stb  <= stx_stb_n;
            txd      <= txd_n;
            load     <= load_n;
            start    <= start_n;
            txrst    <= txrst_n;
        end
    end

    assign bus.spi_tx_data    = stx_data;
    assign bus.spi_tx_strobe  = stx_stb;
    assign bus.tx_data        = txd;
    assign bus.tx_load_strobe = load;
    assign bus.tx_start       = start;
    assign bus.tx_reset       = txrst;
    assign bus.rx_enable      = cfg[0];
    assign bus.loopback       = cfg[1];
endmodule

// File: tb/tb_coax_tx_control.sv
// Directed bench for coax_tx_control: command decode, packing,
// overflow, config writes and mid-transaction reset.
module tb_coax_tx_control;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
    int n_load, n_start, n_rst, n_stx;
    int n_excl = 0;
    logic [7:0] last_stx;
    logic [9:0] words[$];

    coax_tx_control_if bus();

    coax_tx_control #(.MAX_WORDS(4), .DEFAULT_CONFIG(2'b01)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.tx_load_strobe) begin
            n_load++;
            words.push_back(bus.tx_data);
        end
        if (bus.tx_start) n_start++;
        if (bus.tx_reset) n_rst++;
        if (bus.spi_tx_strobe) begin
            n_stx++;
            last_stx = bus.spi_tx_data;
        end
        if (int'(bus.tx_load_strobe) + int'(bus.tx_start)
            + int'(bus.tx_reset) > 1)
            n_excl++;
    end

    task automatic check(string tag, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        n_load = 0;
        n_start = 0;
        n_rst = 0;
        n_stx = 0;
        last_stx = 8'h00;
        words.delete();
    endtask

    task automatic cs_low();
        bus.spi_cs = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic cs_high();
        bus.spi_cs = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic sbyte(input logic [7:0] b);
        @(posedge clk);
        #1;
        bus.spi_rx_data = b;
        bus.spi_rx_strobe = 1'b1;
        @(posedge clk);
        #1;
        bus.spi_rx_strobe = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic int wd(int i);
        if (words.size() > i) return int'(words[i]);
        return -1;
    endfunction

    initial begin
        clr();
        bus.spi_cs = 1'b1;
        bus.spi_rx_data = 8'h00;
        bus.spi_rx_strobe = 1'b0;
        bus.tx_full = 1'b0;
        bus.tx_active = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rxen", int'(bus.rx_enable), 1);
        check("rst_lb", int'(bus.loopback), 0);
        check("rst_stxd", int'(bus.spi_tx_data), 0);
        check("rst_ld", int'(bus.tx_load_strobe), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_strobes", n_load + n_start + n_rst + n_stx, 0);

        // status read
        clr();
        cs_low();
        sbyte(8'h01);
        check("t1_nstx", n_stx, 1);
        check("t1_stat", int'(last_stx), 'h01);
        cs_high();

        // two-word TX
        clr();
        cs_low();
        sbyte(8'h02);
        sbyte(8'h01);
        sbyte(8'h23);
        sbyte(8'h03);
        sbyte(8'hFF);
        cs_high();
        check("t2_nload", n_load, 2);
        check("t2_w0", wd(0), 'h123);
        check("t2_w1", wd(1), 'h3FF);
        check("t2_nstart", n_start, 1);

        // tx_full drop, overflow status, RESET_TX
        clr();
        cs_low();
        sbyte(8'h02);
        sbyte(8'h00);
        sbyte(8'h11);
        bus.tx_full = 1'b1;
        sbyte(8'h00);
        sbyte(8'h22);
        cs_high();
        bus.tx_full = 1'b0;
        check("t3_nload", n_load, 1);
        check("t3_w0", wd(0), 'h011);
        check("t3_nstart", n_start, 1);
        clr();
        cs_low();
        sbyte(8'h01);
        check("t3_stat_ov", int'(last_stx), 'h11);
        bus.tx_active = 1'b1;
        sbyte(8'h00);
        bus.tx_active = 1'b0;
        check("t3_stat_snap", int'(last_stx), 'h15);
        check("t3_nstx", n_stx, 2);
        cs_high();
        clr();
        cs_low();
        sbyte(8'h04);
        sbyte(8'h01);
        cs_high();
        check("t3_nrst", n_rst, 1);
        check("t3_rst_no_stx", n_stx, 0);
        clr();
        cs_low();
        sbyte(8'h01);
        check("t3_stat_clr", int'(last_stx), 'h01);
        cs_high();

        // config write
        clr();
        cs_low();
        sbyte(8'h03);
        sbyte(8'h02);
        sbyte(8'h01);
        cs_high();
        check("t4_lb", int'(bus.loopback), 1);
        check("t4_rxen", int'(bus.rx_enable), 0);
        cs_low();
        sbyte(8'h01);
        check("t4_stat", int'(last_stx), 'h02);
        cs_high();

        // odd byte and unknown opcode
        clr();
        cs_low();
        sbyte(8'h02);
        sbyte(8'h01);
        cs_high();
        check("t5_nload", n_load, 0);
        check("t5_nstart", n_start, 0);
        cs_low();
        sbyte(8'h7E);
        sbyte(8'h55);
        cs_high();
        check("t5_unk", n_load + n_start + n_rst + n_stx, 0);
        check("t5_cfg", int'({bus.loopback, bus.rx_enable}), 2);

        // reset between hi and lo bytes
        clr();
        cs_low();
        sbyte(8'h02);
        sbyte(8'h01);
        reset = 1'b0;
        bus.spi_cs = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_cfg", int'({bus.loopback, bus.rx_enable}), 1);
        check("t6_stxd", int'(bus.spi_tx_data), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("t6_nload", n_load + n_start, 0);
        clr();
        cs_low();
        sbyte(8'h02);
        sbyte(8'h00);
        sbyte(8'hAB);
        cs_high();
        check("t6_w0", wd(0), 'h0AB);
        check("t6_nstart", n_start, 1);

        // word-count saturation at MAX_WORDS=4
        clr();
        cs_low();
        sbyte(8'h02);
        for (int i = 1; i <= 5; i++) begin
            sbyte(8'h00);
            sbyte(8'(i));
        end
        cs_high();
        check("sat_nload", n_load, 4);
        check("sat_w3", wd(3), 'h004);
        check("sat_nstart", n_start, 1);
        cs_low();
        sbyte(8'h01);
        check("sat_stat", int'(last_stx), 'h11);
        cs_high();

        check("excl", n_excl, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
